room_gate_renderer: RTL and testbench

ROOM_GATE_RENDERER -- requirements
Module: room_gate_renderer

---
 rtl/room_gate_renderer.sv | 151 +++++++++++++++
 tb/tb_room_gate_renderer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/room_gate_renderer.sv
// room_gate_renderer
//   Renders a walled room with optional door openings and an animated top gate.
//   The gate slides in GATE_STEP pixels per frame between fully closed
//   (gate height WALL_T) and fully open (height 0) under lock/unlock requests.
//
// Ports
//   clk_vga     in   pixel clock, sole clock
//   rst         in   synchronous active-high reset
//   CurrentX    in   current pixel column
//   CurrentY    in   current pixel row
//   wall        in   wall colour
//   unlock      in   level request to open the top gate
//   lock        in   level request to close the top gate
//   mapData     out  registered pixel colour (1 cycle after CurrentX/CurrentY)
//   gate_open   out  registered: gate FSM is OPEN
//   gate_closed out  registered: gate FSM is CLOSED
module room_gate_renderer #(
    parameter int unsigned WALL_T      = 40,
    parameter int unsigned SCR_W       = 640,
    parameter int unsigned SCR_H       = 480,
    parameter int unsigned DOOR_X_LO   = 260,
    parameter int unsigned DOOR_X_HI   = 380,
    parameter int unsigned DOOR_Y_LO   = 180,
    parameter int unsigned DOOR_Y_HI   = 300,
    parameter logic [3:0]  DOOR_MASK   = 4'b0001,
    parameter logic [7:0]  FLOOR_COLOR = 8'b10110110,
    parameter logic [7:0]  GATE_COLOR  = 8'b00000000,
    parameter int unsigned GATE_STEP   = 4
) (
    input  logic       clk_vga,
    input  logic       rst,
    input  logic [9:0] CurrentX,
    input  logic [8:0] CurrentY,
    input  logic [7:0] wall,
    input  logic       unlock,
    input  logic       lock,
    output logic [7:0] mapData,
    output logic       gate_open,
    output logic       gate_closed
);

    // Wide enough that gate height plus one step never wraps.
    localparam int unsigned GW = $clog2(WALL_T + GATE_STEP + 1);

    localparam logic [GW-1:0] WALL_H = GW'(WALL_T);
    localparam logic [GW-1:0] STEP_H = GW'(GATE_STEP);

    localparam logic [9:0] X_END   = 10'(SCR_W);
    localparam logic [8:0] Y_END   = 9'(SCR_H);
    localparam logic [9:0] X_WALL  = 10'(WALL_T);
    localparam logic [8:0] Y_WALL  = 9'(WALL_T);
    localparam logic [9:0] X_RIGHT = 10'(SCR_W - WALL_T);
    localparam logic [8:0] Y_BOT   = 9'(SCR_H - WALL_T);
    localparam logic [9:0] XD_LO   = 10'(DOOR_X_LO);
    localparam logic [9:0] XD_HI   = 10'(DOOR_X_HI);
    localparam logic [8:0] YD_LO   = 9'(DOOR_Y_LO);
    localparam logic [8:0] YD_HI   = 9'(DOOR_Y_HI);

    typedef enum logic [1:0] {StClosed, StOpening, StOpen, StClosing} state_e;

    state_e        stateQ, stateD;
    logic [GW-1:0] gateHQ, gateHD;
    logic [8:0]    prevYQ;
    logic          frameTick;
    logic          openReq, closeReq;
    logic [GW-1:0] gateDec, gateInc;

    // prevYQ clears to 0 on reset, so the first cycle after reset cannot tick.
    assign frameTick = (CurrentY == 9'd0) && (prevYQ != 9'd0);

    assign openReq  = unlock & ~lock;
    assign closeReq = lock & ~unlock;

    assign gateDec = (gateHQ > STEP_H) ? gateHQ - STEP_H : '0;
    assign gateInc = (gateHQ + STEP_H >= WALL_H) ? WALL_H : gateHQ + STEP_H;

    always_comb begin
        stateD = stateQ;
        gateHD = gateHQ;
        unique case (stateQ)
            StClosed: begin
                if (openReq) stateD = StOpening;
            end
            StOpening: begin
                // Reversal wins over a coincident tick: height frozen this edge.
                if (closeReq) begin
                    stateD = StClosing;
                end else if (frameTick) begin
                    gateHD = gateDec;
                    if (gateDec == '0) stateD = StOpen;
                end
            end
            StOpen: begin
                if (closeReq) stateD = StClosing;
            end
            StClosing: begin
                if (openReq) begin
                    stateD = StOpening;
                end else if (frameTick) begin
                    gateHD = gateInc;
                    if (gateInc == WALL_H) stateD = StClosed;
                end
            end
            default: begin
                stateD = StClosed;
                gateHD = WALL_H;
            end
        endcase
    end

    // Pixel classification.
    logic inXDoor, inYDoor, offScreen, wallPix, gatePix;
    logic [7:0] pixD;

    assign inXDoor   = (CurrentX >= XD_LO) && (CurrentX < XD_HI);
    assign inYDoor   = (CurrentY >= YD_LO) && (CurrentY < YD_HI);
    assign offScreen = (CurrentX >= X_END) || (CurrentY >= Y_END);

    assign wallPix = ((CurrentY < Y_WALL)   && !(DOOR_MASK[0] && inXDoor)) ||
                     ((CurrentX < X_WALL)   && !(DOOR_MASK[1] && inYDoor)) ||
                     ((CurrentX >= X_RIGHT) && !(DOOR_MASK[2] && inYDoor)) ||
                     ((CurrentY >= Y_BOT)   && !(DOOR_MASK[3] && inXDoor));

    assign gatePix = DOOR_MASK[0] && inXDoor && ({1'b0, CurrentY} < 10'(gateHQ));

    always_comb begin
        pixD = FLOOR_COLOR;
        if (offScreen)    pixD = 8'h00;
        else if (gatePix) pixD = GATE_COLOR;
        else if (wallPix) pixD = wall;
    end

    always_ff @(posedge clk_vga) begin
        if (rst) begin
            stateQ      <= StClosed;
            gateHQ      <= WALL_H;
            prevYQ      <= 9'd0;
            mapData     <= 8'h00;
            gate_open   <= 1'b0;
            gate_closed <= 1'b1;
        end else begin
            stateQ      <= stateD;
            gateHQ      <= gateHD;
            prevYQ      <= CurrentY;
            mapData     <= pixD;
            gate_open   <= (stateQ == StOpen);
            gate_closed <= (stateQ == StClosed);
        end
    end

endmodule

// File: tb/tb_room_gate_renderer.sv
// Directed bench for room_gate_renderer: a default instance (top door only,
// step 4) and an all-doors instance with a one-frame gate (step 40).
module tb_room_gate_renderer;

    logic       clk_vga = 1'b0;
    logic       rst;
    logic [9:0] CurrentX;
    logic [8:0] CurrentY;
    logic [7:0] wall;
    logic       unlock, lock;
    logic [7:0] mapData1, mapData2;
    logic       gateOpen1, gateClosed1, gateOpen2, gateClosed2;

    int checks   = 0;
    int failures = 0;

    localparam logic [7:0] FLOOR = 8'b10110110;
    localparam logic [7:0] WALLC = 8'h5A;

    always #5 clk_vga = ~clk_vga;

    room_gate_renderer dut1 (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .CurrentX   (CurrentX),
        .CurrentY   (CurrentY),
        .wall       (wall),
        .unlock     (unlock),
        .lock       (lock),
        .mapData    (mapData1),
        .gate_open  (gateOpen1),
        .gate_closed(gateClosed1)
    );

    room_gate_renderer #(
        .DOOR_MASK(4'b1111),
        .GATE_STEP(40)
    ) dut2 (
        .clk_vga    (clk_vga),
        .rst        (rst),
        .CurrentX   (CurrentX),
        .CurrentY   (CurrentY),
        .wall       (wall),
        .unlock     (unlock),
        .lock       (lock),
        .mapData    (mapData2),
        .gate_open  (gateOpen2),
        .gate_closed(gateClosed2)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs read there too.
    task automatic step();
        @(posedge clk_vga);
        #1;
    endtask

    task automatic px1(input string tag, input int x, input int y, input logic [7:0] exp);
        CurrentX = 10'(x);
        CurrentY = 9'(y);
        step();
        chk(tag, 32'(mapData1), 32'(exp));
    endtask

    task automatic px2(input string tag, input int x, input int y, input logic [7:0] exp);
        CurrentX = 10'(x);
        CurrentY = 9'(y);
        step();
        chk(tag, 32'(mapData2), 32'(exp));
    endtask

    // One frame boundary: a row-0 cycle following a nonzero row.
    task automatic frame();
        CurrentY = 9'd0;
        step();
        CurrentY = 9'd100;
        step();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        rst      = 1'b1;
        CurrentX = 10'd300;
        CurrentY = 9'd100;
        wall     = WALLC;
        unlock   = 1'b0;
        lock     = 1'b0;
        step();
        step();
        chk("rst_mapData", 32'(mapData1), 32'h00);
        chk("rst_gate_closed", 32'(gateClosed1), 32'd1);
        chk("rst_gate_open", 32'(gateOpen1), 32'd0);
        chk("rst_gate_h", 32'(dut1.gateHQ), 32'd40);
        rst = 1'b0;

        // Static scene, gate fully closed.
        px1("pix_gate_closed", 300, 20, 8'h00);
        px1("pix_floor", 300, 200, FLOOR);
        px1("pix_left_wall", 10, 200, WALLC);
        px1("pix_right_wall", 630, 200, WALLC);
        px1("pix_bottom_wall", 300, 470, WALLC);
        px1("pix_top_wall_outside_door", 100, 20, WALLC);
        px1("pix_offscreen_x", 700, 10, 8'h00);
        px1("pix_offscreen_y", 300, 480, 8'h00);

        // Full opening: 10 frames of 4 pixels.
        CurrentX = 10'd300;
        CurrentY = 9'd100;
        unlock = 1'b1;
        step();
        unlock = 1'b0;
        chk("open_start_h", 32'(dut1.gateHQ), 32'd40);
        for (int i = 1; i <= 10; i++) begin
            frame();
            chk($sformatf("open_h_f%0d", i), 32'(dut1.gateHQ), 32'(40 - 4 * i));
            chk($sformatf("open_flag_f%0d", i), 32'(gateOpen1), 32'(i == 10));
        end
        chk("open_gate_closed", 32'(gateClosed1), 32'd0);
        px1("pix_gate_open", 300, 20, FLOOR);

        // Reversal at height 24, coinciding with a frame tick.
        do_reset();
        CurrentY = 9'd100;
        unlock = 1'b1;
        step();
        unlock = 1'b0;
        for (int i = 0; i < 4; i++) frame();
        chk("rev_pre_h", 32'(dut1.gateHQ), 32'd24);
        lock = 1'b1;
        CurrentY = 9'd0;
        step();
        chk("rev_h_held", 32'(dut1.gateHQ), 32'd24);
        lock = 1'b0;
        CurrentY = 9'd100;
        step();
        chk("rev_h_after", 32'(dut1.gateHQ), 32'd24);
        px1("rev_pix_in_gate", 300, 23, 8'h00);
        px1("rev_pix_below_gate", 300, 24, FLOOR);
        for (int i = 1; i <= 4; i++) begin
            frame();
            chk($sformatf("close_h_f%0d", i), 32'(dut1.gateHQ), 32'(24 + 4 * i));
            chk($sformatf("close_flag_f%0d", i), 32'(gateClosed1), 32'(i == 4));
        end

        // Both requests in CLOSED: nothing moves.
        unlock = 1'b1;
        lock   = 1'b1;
        for (int i = 0; i < 3; i++) frame();
        chk("both_closed_h", 32'(dut1.gateHQ), 32'd40);
        chk("both_closed_flag", 32'(gateClosed1), 32'd1);
        chk("both_closed_open", 32'(gateOpen1), 32'd0);
        unlock = 1'b0;
        lock   = 1'b0;

        // Both requests while OPENING: motion continues.
        unlock = 1'b1;
        step();
        unlock = 1'b1;
        lock   = 1'b1;
        frame();
        frame();
        chk("both_opening_h", 32'(dut1.gateHQ), 32'd32);
        chk("both_opening_closed", 32'(gateClosed1), 32'd0);
        chk("both_opening_open", 32'(gateOpen1), 32'd0);
        unlock = 1'b0;
        lock   = 1'b0;
        for (int i = 0; i < 5; i++) frame();
        chk("pre_abort_open_h", 32'(dut1.gateHQ), 32'd12);

        // Reverse to CLOSING at 12, then reset aborts the motion.
        lock = 1'b1;
        step();
        lock = 1'b0;
        chk("closing_h12", 32'(dut1.gateHQ), 32'd12);
        CurrentX = 10'd300;
        CurrentY = 9'd200;
        rst = 1'b1;
        step();
        chk("abort_h", 32'(dut1.gateHQ), 32'd40);
        chk("abort_closed", 32'(gateClosed1), 32'd1);
        chk("abort_open", 32'(gateOpen1), 32'd0);
        chk("abort_mapData", 32'(mapData1), 32'h00);
        rst = 1'b0;
        px1("post_abort_floor", 300, 200, FLOOR);

        // All-doors instance.
        px2("all_left_door", 10, 200, FLOOR);
        px2("all_right_door", 630, 200, FLOOR);
        px2("all_bottom_door", 300, 470, FLOOR);
        px2("all_top_gate", 300, 20, 8'h00);
        px2("all_left_wall", 10, 100, WALLC);
        px2("all_corner", 10, 10, WALLC);
        chk("all_pre_open", 32'(gateOpen2), 32'd0);
        CurrentY = 9'd100;
        unlock = 1'b1;
        step();
        unlock = 1'b0;
        frame();
        chk("all_h_one_frame", 32'(dut2.gateHQ), 32'd0);
        chk("all_open_one_frame", 32'(gateOpen2), 32'd1);
        px2("all_top_open", 300, 20, FLOOR);
        px2("all_offscreen_x", 700, 10, 8'h00);
        px2("all_offscreen_y", 10, 480, 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
